// File: rtl/parking_entry_gate.sv
// Entry-lane controller: debounces the loop detector, asks can_park, drives the barrier
// and emits one car_arrive per admitted vehicle. Define GATE_STATS_EN for reject/timeout counters.
module parking_entry_gate #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GATE_TIMEOUT    = 32,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_in,
    input  logic             pass_sensor,
    input  logic             can_park,
    output logic             car_arrive,
    output logic             gate_open,
    output logic             full_lamp,
    output logic             busy,
    output logic [CNT_W-1:0] entry_count
`ifdef GATE_STATS_EN
    ,
    output logic [CNT_W-1:0] reject_count,
    output logic [CNT_W-1:0] timeout_count
`endif
);

    localparam int DBC_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = $clog2(GATE_TIMEOUT);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DETECT,
        ST_REQUEST,
        ST_OPEN,
        ST_CLEAR,
        ST_REJECT
    } state_t;

    state_t             r_state;
    logic [DBC_W-1:0]   r_dbc;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_sens_meta, r_sens_sync;
    logic               r_pass_meta, r_pass_sync, r_pass_prev;
    logic               r_car_arrive, r_gate_open, r_full_lamp, r_busy;
    logic [CNT_W-1:0]   r_entry_cnt;
    logic               w_pass_rise;
`ifdef GATE_STATS_EN
    logic [CNT_W-1:0]   r_reject_cnt, r_timeout_cnt;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Both raw sensors are asynchronous to clk; only the synced copies reach the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sens_meta <= 1'b0;
            r_sens_sync <= 1'b0;
            r_pass_meta <= 1'b0;
            r_pass_sync <= 1'b0;
            r_pass_prev <= 1'b0;
        end else begin
            r_sens_meta <= sensor_in;
            r_sens_sync <= r_sens_meta;
            r_pass_meta <= pass_sensor;
            r_pass_sync <= r_pass_meta;
            r_pass_prev <= r_pass_sync;
        end
    end

    assign w_pass_rise = r_pass_sync & ~r_pass_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_dbc         <= '0;
            r_tmr         <= '0;
            r_car_arrive  <= 1'b0;
            r_gate_open   <= 1'b0;
            r_full_lamp   <= 1'b0;
            r_busy        <= 1'b0;
            r_entry_cnt   <= '0;
`ifdef GATE_STATS_EN
            r_reject_cnt  <= '0;
            r_timeout_cnt <= '0;
`endif
        end else begin
            r_car_arrive <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_sens_sync) begin
                        r_busy <= 1'b1;
                        r_dbc  <= DBC_W'(1);
                        r_state <= (DEBOUNCE_CYCLES == 1) ? ST_REQUEST : ST_DETECT;
                    end
                end
                ST_DETECT: begin
                    if (!r_sens_sync) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dbc <= r_dbc + 1'b1;
                        // This cycle's high sample is the DEBOUNCE_CYCLES-th in a row.
                        if (r_dbc == DBC_LAST)
                            r_state <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (can_park) begin
                        r_state     <= ST_OPEN;
                        r_tmr       <= '0;
                        r_gate_open <= 1'b1;
                    end else begin
                        r_state     <= ST_REJECT;
                        r_full_lamp <= 1'b1;
`ifdef GATE_STATS_EN
                        r_reject_cnt <= sat_inc(r_reject_cnt);
`endif
                    end
                end
                ST_OPEN: begin
                    r_tmr <= r_tmr + 1'b1;
                    // A pass edge on the timeout cycle still counts as an admission.
                    if (w_pass_rise) begin
                        r_state      <= ST_CLEAR;
                        r_car_arrive <= 1'b1;
                        r_entry_cnt  <= sat_inc(r_entry_cnt);
                    end else if (r_tmr == TMR_LAST) begin
                        r_state <= ST_CLEAR;
`ifdef GATE_STATS_EN
                        r_timeout_cnt <= sat_inc(r_timeout_cnt);
`endif
                    end
                end
                ST_CLEAR: begin
                    if (!r_pass_sync && !r_sens_sync) begin
                        r_state     <= ST_IDLE;
                        r_gate_open <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                ST_REJECT: begin
                    if (!r_sens_sync) begin
                        r_state     <= ST_IDLE;
                        r_full_lamp <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gate_open <= 1'b0;
                    r_full_lamp <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign car_arrive  = r_car_arrive;
    assign gate_open   = r_gate_open;
    assign full_lamp   = r_full_lamp;
    assign busy        = r_busy;
    assign entry_count = r_entry_cnt;
`ifdef GATE_STATS_EN
    assign reject_count  = r_reject_cnt;
    assign timeout_count = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_parking_entry_gate.sv
// Directed bench for parking_entry_gate: default-parameter instance plus a CNT_W=2 twin
// sharing the same lane stimulus for counter saturation.
module tb_parking_entry_gate;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_in = 1'b0;
    logic       pass_sensor = 1'b0;
    logic       can_park = 1'b0;
    logic       car_arrive, gate_open, full_lamp, busy;
    logic [7:0] entry_count;
    logic       car_arrive2, gate_open2, full_lamp2, busy2;
    logic [1:0] entry_count2;
`ifdef GATE_STATS_EN
    logic [7:0] reject_count, timeout_count;
    logic [1:0] reject_count2, timeout_count2;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int n_arr = 0;
    int n_arr2 = 0;

    parking_entry_gate dut (
        .clk(clk), .rst_n(rst_n), .sensor_in(sensor_in), .pass_sensor(pass_sensor),
        .can_park(can_park), .car_arrive(car_arrive), .gate_open(gate_open),
        .full_lamp(full_lamp), .busy(busy), .entry_count(entry_count)
`ifdef GATE_STATS_EN
        , .reject_count(reject_count), .timeout_count(timeout_count)
`endif
    );

    parking_entry_gate #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sensor_in(sensor_in), .pass_sensor(pass_sensor),
        .can_park(can_park), .car_arrive(car_arrive2), .gate_open(gate_open2),
        .full_lamp(full_lamp2), .busy(busy2), .entry_count(entry_count2)
`ifdef GATE_STATS_EN
        , .reject_count(reject_count2), .timeout_count(timeout_count2)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (car_arrive)  n_arr++;
        if (car_arrive2) n_arr2++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_closed(input string tag);
        int k = 0;
        while (gate_open && k < 20) begin
            tick(1);
            k++;
        end
        chk(tag, {31'd0, gate_open}, 0);
    endtask

    task automatic admit(input int exp_cnt);
        int a0 = n_arr;
        sensor_in = 1'b1;
        can_park  = 1'b1;
        tick(7);
        chk("adm_gate", {31'd0, gate_open}, 1);
        pass_sensor = 1'b1;
        tick(3);
        chk("adm_pulse", {31'd0, car_arrive}, 1);
        sensor_in   = 1'b0;
        pass_sensor = 1'b0;
        wait_closed("adm_close");
        chk("adm_npulse", n_arr - a0, 1);
        chk("adm_cnt", {24'd0, entry_count}, exp_cnt);
        chk("adm_cnt_sat", {30'd0, entry_count2}, (exp_cnt > 3) ? 3 : exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a0, seen;

        // Reset state
        tick(2);
        chk("rst_gate", {31'd0, gate_open}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_lamp", {31'd0, full_lamp}, 0);
        chk("rst_arrive", {31'd0, car_arrive}, 0);
        chk("rst_cnt", {24'd0, entry_count}, 0);
        rst_n = 1'b1;
        tick(2);

        // Normal entry: gate opens exactly 7 cycles after sensor_in rises
        sensor_in = 1'b1;
        can_park  = 1'b1;
        tick(6);
        chk("lat_gate_early", {31'd0, gate_open}, 0);
        chk("lat_busy", {31'd0, busy}, 1);
        tick(1);
        chk("lat_gate", {31'd0, gate_open}, 1);
        tick(2);
        pass_sensor = 1'b1;
        tick(2);
        chk("norm_no_early_pulse", {31'd0, car_arrive}, 0);
        tick(1);
        chk("norm_pulse", {31'd0, car_arrive}, 1);
        chk("norm_cnt", {24'd0, entry_count}, 1);
        tick(1);
        chk("norm_pulse_1cyc", {31'd0, car_arrive}, 0);
        chk("norm_clear_open", {31'd0, gate_open}, 1);
        // Tailgater: a second beam break while clearing earns no pulse
        pass_sensor = 1'b0;
        tick(3);
        pass_sensor = 1'b1;
        tick(4);
        chk("tail_npulse", n_arr, 1);
        chk("tail_cnt", {24'd0, entry_count}, 1);
        sensor_in   = 1'b0;
        pass_sensor = 1'b0;
        wait_closed("norm_close");
        chk("norm_busy_end", {31'd0, busy}, 0);
        chk("norm_cnt2", {30'd0, entry_count2}, 1);

        // Glitch: only 3 synced-high cycles, debounce never completes
        sensor_in = 1'b1;
        tick(3);
        sensor_in = 1'b0;
        seen = 0;
        repeat (15) begin
            tick(1);
            if (gate_open) seen++;
        end
        chk("glitch_gate", seen, 0);
        chk("glitch_busy", {31'd0, busy}, 0);

        // Lot full
        a0 = n_arr;
        can_park  = 1'b0;
        sensor_in = 1'b1;
        tick(6);
        chk("full_lamp_early", {31'd0, full_lamp}, 0);
        tick(1);
        chk("full_lamp", {31'd0, full_lamp}, 1);
        chk("full_gate", {31'd0, gate_open}, 0);
        tick(5);
        can_park = 1'b1;
        tick(3);
        chk("full_no_recheck_lamp", {31'd0, full_lamp}, 1);
        chk("full_no_recheck_gate", {31'd0, gate_open}, 0);
        sensor_in = 1'b0;
        tick(3);
        chk("full_lamp_off", {31'd0, full_lamp}, 0);
        chk("full_busy_off", {31'd0, busy}, 0);
        chk("full_npulse", n_arr - a0, 0);
`ifdef GATE_STATS_EN
        chk("stat_reject", {24'd0, reject_count}, 1);
`endif

        // Timeout, no pass: 32 cycles in OPEN then closes once sensor is low
        a0 = n_arr;
        sensor_in = 1'b1;
        tick(7);
        chk("to_gate", {31'd0, gate_open}, 1);
        sensor_in = 1'b0;
        tick(32);
        chk("to_hold", {31'd0, gate_open}, 1);
        tick(1);
        chk("to_close", {31'd0, gate_open}, 0);
        chk("to_npulse", n_arr - a0, 0);
`ifdef GATE_STATS_EN
        chk("stat_timeout1", {24'd0, timeout_count}, 1);
`endif

        // Pass edge lands on the timeout cycle: pass wins
        sensor_in = 1'b1;
        tick(7);
        sensor_in = 1'b0;
        tick(29);
        pass_sensor = 1'b1;
        tick(2);
        chk("tie_no_early", {31'd0, car_arrive}, 0);
        tick(1);
        chk("tie_pulse", {31'd0, car_arrive}, 1);
        chk("tie_cnt", {24'd0, entry_count}, 2);
        pass_sensor = 1'b0;
        wait_closed("tie_close");

        // Pass edge one cycle after timeout: ignored
        a0 = n_arr;
        sensor_in = 1'b1;
        tick(7);
        sensor_in = 1'b0;
        tick(30);
        pass_sensor = 1'b1;
        tick(3);
        chk("late_no_pulse", {31'd0, car_arrive}, 0);
        tick(3);
        chk("late_npulse", n_arr - a0, 0);
        chk("late_hold", {31'd0, gate_open}, 1);
        pass_sensor = 1'b0;
        wait_closed("late_close");
        chk("late_cnt", {24'd0, entry_count}, 2);
`ifdef GATE_STATS_EN
        chk("stat_timeout2", {24'd0, timeout_count}, 2);
`endif

        // Saturation of the CNT_W=2 twin
        admit(3);
        admit(4);
        admit(5);
        chk("sat_pulses2", n_arr2, 5);

        // Async reset mid-OPEN with a pulse pending
        sensor_in = 1'b1;
        can_park  = 1'b1;
        tick(7);
        pass_sensor = 1'b1;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gate", {31'd0, gate_open}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_cnt", {24'd0, entry_count}, 0);
        chk("arst_cnt2", {30'd0, entry_count2}, 0);
        a0 = n_arr;
        tick(2);
        chk("arst_no_pulse", n_arr - a0, 0);
`ifdef GATE_STATS_EN
        chk("arst_stats", {24'd0, reject_count | timeout_count}, 0);
`endif
        sensor_in   = 1'b0;
        pass_sensor = 1'b0;
        rst_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
